uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter; the transmit-side counterpart of the oversampling UART receiver in the same multi-clock system.
- Accepts one parallel word per handshake and serialises it LSB-first on TX_OUT: start bit, DATA data bits, optional parity bit, one stop bit.
- Each bit is held for prescale CLK cycles, so TX and RX can share one clock and prescale setting.
- Sits between the TX async FIFO read side and the UART pin.

Parameters:
DATA, 8, data word width in bits (supported range 5..9).

Ports:
CLK  input  1  block clock.
RST  input  1  reset; synchronous, active-high.
P_DATA  input  DATA  parallel word to send; sampled only on accept.
Data_Valid  input  1  request to send P_DATA; single-cycle or held.
PAR_EN  input  1  1 = append parity bit; sampled on accept.
PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
prescale  input  6  CLK cycles per bit; sampled on accept; value 0 treated as 1.
TX_OUT  output  1  serial line; registered; idles high.
Busy  output  1  high while a frame is in progress; registered.

Behaviour:
Reset and accept:
- Reset (at any CLK edge with RST=1, including mid-frame): next cycle TX_OUT=1, Busy=0, FSM=IDLE, all counters and shadow registers cleared. The frame in progress is aborted without a stop bit.
- Accept condition: FSM=IDLE and Data_Valid=1 at edge N.
- On accept, latch into shadow registers: P_DATA, PAR_EN, PAR_TYP, max(prescale,1).
- Parity is computed from the latched data: even = XOR of data bits; odd = inverted XOR.
- Input changes after accept have no effect on the current frame.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept.
- START -> DATA after P cycles.
- DATA -> PARITY (PAR_EN=1) or STOP (PAR_EN=0) after DATA*P cycles.
- PARITY -> STOP after P cycles.
- STOP -> IDLE after P cycles.

Counters:
- edge counter (6-bit) runs 0..P-1, wraps to 0 at each bit boundary.
- bit index (4-bit) runs 0..DATA-1 in the DATA state.

Frame timing (P = latched prescale):
- From edge N+1, TX_OUT drives start bit 0 for P cycles.
- Then data bits LSB-first, P cycles each; then parity (if enabled) for P cycles; then stop bit 1 for P cycles.
- Frame length F = (DATA + 2 + PAR_EN) * P cycles.
- Busy=1 from edge N+1 for exactly F cycles, asserted and deasserted on the same edges as the frame's first and last bit period.
- TX_OUT=1 whenever FSM=IDLE.

Boundaries:
- Data_Valid while Busy=1 (including the final stop cycle) is ignored. No queueing, no error flag. The upstream is responsible for holding Data_Valid until it sees Busy=0.
- Back-to-back: Data_Valid high in the first cycle after Busy falls is accepted. The minimum gap between frames is 1 idle-high cycle.
- prescale=1: each bit lasts one cycle; the edge counter stays at 0.
- RST and Data_Valid in the same cycle: reset wins; no accept.

Test Plan:
- DATA=8, prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each bit exactly 8 cycles; start begins one cycle after accept; Busy high exactly 88 cycles.
- Same frame with PAR_TYP=1 -> parity bit = 1; all other bits unchanged; Busy 88 cycles.
- PAR_EN=0, prescale=1, P_DATA=0x3C -> TX_OUT 0,0,0,1,1,1,1,0,0,1 on 10 consecutive cycles; Busy high 10 cycles; TX_OUT=1 afterwards.
- Mid-frame at prescale=16: pulse Data_Valid with P_DATA=0xFF and change prescale to 4 -> current frame bits and 16-cycle bit timing unchanged; 0xFF never transmitted.
- Hold Data_Valid high continuously with P_DATA=0x55, PAR_EN=0, prescale=8 -> consecutive 80-cycle frames separated by exactly one idle-high cycle.
- Assert RST for one cycle during bit 3 of a frame -> next cycle TX_OUT=1, Busy=0; a Data_Valid one cycle later starts a clean new frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: serialises one latched word per handshake as
// start bit, DATA data bits LSB-first, optional parity bit and one stop bit,
// with every bit held for the latched prescale count of CLK cycles.
module uart_tx #(
    parameter int DATA = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [DATA-1:0] P_DATA,
    input  logic            Data_Valid,
    input  logic            PAR_EN,
    input  logic            PAR_TYP,
    input  logic [5:0]      prescale,
    output logic            TX_OUT,
    output logic            Busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [DATA-1:0] data_q, data_d;
    logic            par_en_q, par_en_d;
    logic            par_typ_q, par_typ_d;
    logic [5:0]      presc_q, presc_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic            bit_last;
    logic            data_bit_d;
    logic            par_bit_d;

    // Last cycle of the current bit period; the shadow prescale is never 0
    // while a frame is running, so P-1 cannot underflow there.
    assign bit_last = (cnt_q == presc_q - 6'd1);

    // Next-state logic: accept in IDLE, then step through the frame bit by bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        presc_d   = presc_q;
        case (state_q)
            S_IDLE: begin
                if (Data_Valid) begin
                    state_d   = S_START;
                    cnt_d     = 6'd0;
                    bit_d     = 4'd0;
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    presc_d   = (prescale == 6'd0) ? 6'd1 : prescale;
                end
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                    cnt_d   = 6'd0;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    cnt_d = 6'd0;
                    if (bit_q == 4'(DATA - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_PARITY: begin
                if (bit_last) begin
                    state_d = S_STOP;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_STOP: begin
                if (bit_last) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state so that the
    // registered outputs change on the same edge as the state itself.
    always_comb begin
        data_bit_d = 1'b0;
        for (int i = 0; i < DATA; i++) begin
            if (bit_d == 4'(i)) data_bit_d = data_d[i];
        end
        par_bit_d = (^data_d) ^ par_typ_d;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_bit_d;
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any frame and returns the line high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            bit_q     <= 4'd0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= 6'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            presc_q   <= presc_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
